serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor that processes one bit per clock, LSB first.
- Uses a start/done handshake and a mode input for add or subtract (two's complement).
- Reports carry-out and signed overflow.
- Sits in the datapath wherever area matters more than latency; the controller issues operations through the handshake.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/fa_cell.sv | 16 +
 rtl/serial_addsub.sv | 120 ++++++++++++
 tb/tb_serial_addsub.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_pkg;

  // Controller states: waiting, shifting one bit per clock, result ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width; it only has to reach WIDTH-1, so $clog2 is enough
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder used as the serial arithmetic core.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, start/done handshake.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_co;
  logic             last_bit;
  logic             accept;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_co)
  );

  // Result bits gathered so far with the current sum bit entering at the MSB
  always_comb begin
    r_next   = {bit_s, r_sr};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Next-state, handshake outputs and operand acceptance
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand shifters, partial result, carry and bit counter; subtract is A + ~B + 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sr  <= a_in;
      b_sr  <= sub ? ~b_in : b_in;
      carry <= sub;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= r_next[WIDTH-1:1];
      carry <= bit_co;
      cnt   <= cnt + 1'b1;
    end
  end

  // Publish the result on the last shift so it is valid together with done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      sum  <= r_next;
      cout <= bit_co;
      ovf  <= carry ^ bit_co;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=4 and WIDTH=8.
module tb_serial_addsub;

  logic clk;
  logic rst4, start4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  logic rst8, start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  int total = 0;
  int bad = 0;

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(rst4), .start(start4), .sub(sub4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .sub(sub8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [33:0] actual, input logic [33:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Arithmetic reference: returns {ovf, cout, sum[31:0]} for a w-bit operation
  function automatic logic [33:0] calc(input int w, input longint a, input longint b, input bit s);
    longint m, ua, ub, tot, sa, sb, r;
    logic ov, co;
    m   = (longint'(1) << w) - 1;
    ua  = a & m;
    ub  = b & m;
    tot = s ? ua + ((~ub) & m) + 1 : ua + ub;
    co  = ((tot >> w) & 1) != 0;
    sa  = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    sb  = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    r   = s ? sa - sb : sa + sb;
    ov  = (r > (m >> 1)) || (r < -((m >> 1) + 1));
    return {ov, co, 32'(tot & m)};
  endfunction

  // Timing model for the 4-bit instance: countdown of remaining shift cycles
  int m4Remain;
  logic m4Busy, m4Done, m4Cout, m4Ovf;
  logic [3:0] m4Sum;
  logic [33:0] m4Pend;
  always @(posedge clk or posedge rst4) begin
    if (rst4) begin
      m4Remain = 0; m4Busy = 0; m4Done = 0; m4Sum = 0; m4Cout = 0; m4Ovf = 0;
    end else if (m4Remain > 0) begin
      m4Remain--;
      if (m4Remain == 0) begin
        m4Busy = 0; m4Done = 1;
        m4Sum = m4Pend[3:0]; m4Cout = m4Pend[32]; m4Ovf = m4Pend[33];
      end
    end else begin
      m4Done = 0;
      if (start4) begin
        m4Pend = calc(4, longint'(a4), longint'(b4), sub4);
        m4Remain = 4; m4Busy = 1;
      end
    end
  end

  // Timing model for the 8-bit instance
  int m8Remain;
  logic m8Busy, m8Done, m8Cout, m8Ovf;
  logic [7:0] m8Sum;
  logic [33:0] m8Pend;
  always @(posedge clk or posedge rst8) begin
    if (rst8) begin
      m8Remain = 0; m8Busy = 0; m8Done = 0; m8Sum = 0; m8Cout = 0; m8Ovf = 0;
    end else if (m8Remain > 0) begin
      m8Remain--;
      if (m8Remain == 0) begin
        m8Busy = 0; m8Done = 1;
        m8Sum = m8Pend[7:0]; m8Cout = m8Pend[32]; m8Ovf = m8Pend[33];
      end
    end else begin
      m8Done = 0;
      if (start8) begin
        m8Pend = calc(8, longint'(a8), longint'(b8), sub8);
        m8Remain = 8; m8Busy = 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the models
  always @(negedge clk) begin
    checkOutput("busy4", 34'(busy4), 34'(m4Busy));
    checkOutput("done4", 34'(done4), 34'(m4Done));
    checkOutput("sum4",  34'(sum4),  34'(m4Sum));
    checkOutput("cout4", 34'(cout4), 34'(m4Cout));
    checkOutput("ovf4",  34'(ovf4),  34'(m4Ovf));
    checkOutput("busy8", 34'(busy8), 34'(m8Busy));
    checkOutput("done8", 34'(done8), 34'(m8Done));
    checkOutput("sum8",  34'(sum8),  34'(m8Sum));
    checkOutput("cout8", 34'(cout8), 34'(m8Cout));
    checkOutput("ovf8",  34'(ovf8),  34'(m8Ovf));
  end

  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic s);
    @(negedge clk);
    #1;
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    #1;
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
  endtask

  // Count cycles until done, dropping start after the first one, and check sum holds while busy
  task automatic waitDone4(input logic [3:0] hold, output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start4 = 1'b0;
      if (busy4) begin
        busyCnt++;
        checkOutput("hold4", 34'(sum4), 34'(hold));
      end
      if (done4) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) checkOutput("timeout4", 34'(0), 34'(1));
  endtask

  task automatic waitDone8(input logic [7:0] hold, output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start8 = 1'b0;
      if (busy8) begin
        busyCnt++;
        checkOutput("hold8", 34'(sum8), 34'(hold));
      end
      if (done8) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) checkOutput("timeout8", 34'(0), 34'(1));
  endtask

  task automatic runOp4(input string name, input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [3:0] hold, input logic [3:0] eSum, input logic eCout, input logic eOvf);
    int lat, bc;
    applyStimulus4(a, b, s);
    waitDone4(hold, lat, bc);
    checkOutput({name, "_lat"},  34'(lat),   34'(5));
    checkOutput({name, "_busy"}, 34'(bc),    34'(4));
    checkOutput({name, "_sum"},  34'(sum4),  34'(eSum));
    checkOutput({name, "_cout"}, 34'(cout4), 34'(eCout));
    checkOutput({name, "_ovf"},  34'(ovf4),  34'(eOvf));
  endtask

  task automatic runOp8(input string name, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] hold, input logic [7:0] eSum, input logic eCout, input logic eOvf);
    int lat, bc;
    applyStimulus8(a, b, s);
    waitDone8(hold, lat, bc);
    checkOutput({name, "_lat"},  34'(lat),   34'(9));
    checkOutput({name, "_busy"}, 34'(bc),    34'(8));
    checkOutput({name, "_sum"},  34'(sum8),  34'(eSum));
    checkOutput({name, "_cout"}, 34'(cout8), 34'(eCout));
    checkOutput({name, "_ovf"},  34'(ovf8),  34'(eOvf));
  endtask

  // Safety net against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence
  initial begin
    int lat, bc;
    rst4 = 0; rst8 = 0;
    start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    #2;
    rst4 = 1; rst8 = 1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy4", 34'(busy4), 34'(0));
    checkOutput("rst_done4", 34'(done4), 34'(0));
    checkOutput("rst_sum8",  34'(sum8),  34'(0));

    checkOutput("model_5p3",   calc(4, 5, 3, 0),        {1'b1, 1'b0, 32'h8});
    checkOutput("model_8m1",   calc(4, 8, 1, 1),        {1'b1, 1'b1, 32'h7});
    checkOutput("model_3m5",   calc(4, 3, 5, 1),        {1'b0, 1'b0, 32'hE});
    checkOutput("model_ffpff", calc(8, 'hFF, 'hFF, 0),  {1'b0, 1'b1, 32'hFE});

    #1;
    rst4 = 0; rst8 = 0;

    runOp4("add_5_3",  4'h5, 4'h3, 1'b0, 4'h0, 4'h8, 1'b0, 1'b1);
    runOp4("add_f_1",  4'hF, 4'h1, 1'b0, 4'h8, 4'h0, 1'b1, 1'b0);
    runOp4("sub_8_1",  4'h8, 4'h1, 1'b1, 4'h0, 4'h7, 1'b1, 1'b1);
    runOp4("sub_3_5",  4'h3, 4'h5, 1'b1, 4'h7, 4'hE, 1'b0, 1'b0);

    // start pulsed mid-operation must not disturb the running add
    applyStimulus4(4'h9, 4'h4, 1'b0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done4) begin
        lat = n;
        break;
      end
      if (n == 1) start4 = 1'b0;
      if (n == 2) begin a4 = 4'h1; b4 = 4'h1; start4 = 1'b1; end
      if (n == 3) start4 = 1'b0;
    end
    checkOutput("ign_lat", 34'(lat),  34'(5));
    checkOutput("ign_sum", 34'(sum4), 34'(4'hD));

    // start held through DONE launches the next operation back-to-back
    applyStimulus4(4'h3, 4'h3, 1'b0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin a4 = 4'h2; b4 = 4'h2; end
      if (done4) begin
        lat = n;
        break;
      end
    end
    checkOutput("b2b_lat1", 34'(lat),  34'(5));
    checkOutput("b2b_sum1", 34'(sum4), 34'(4'h6));
    waitDone4(4'h6, lat, bc);
    checkOutput("b2b_lat2", 34'(lat),  34'(5));
    checkOutput("b2b_sum2", 34'(sum4), 34'(4'h4));

    // asynchronous reset mid-operation aborts and clears outputs
    applyStimulus4(4'h9, 4'h9, 1'b0);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #1;
    rst4 = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 34'(busy4), 34'(0));
    checkOutput("mid_rst_done", 34'(done4), 34'(0));
    checkOutput("mid_rst_sum",  34'(sum4),  34'(0));
    checkOutput("mid_rst_cout", 34'(cout4), 34'(0));
    checkOutput("mid_rst_ovf",  34'(ovf4),  34'(0));
    @(negedge clk);
    #1;
    rst4 = 1'b0;
    runOp4("add_6_7",  4'h6, 4'h7, 1'b0, 4'h0, 4'hD, 1'b0, 1'b1);

    runOp8("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b0);
    runOp8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'hFE, 8'h7F, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
